// File: rtl/jtag_tap_regs.sv
// jtag_tap_regs: IR plus BYPASS/IDCODE/USER data registers behind a JTAG TAP, with falling-edge TDO.
// Define JTAG_USERCODE_EN to add a 32-bit USERCODE register on opcode 2.
module jtag_tap_regs #(
    parameter int                IR_W         = 4,
    parameter logic [31:0]       IDCODE_VAL   = 32'h1000_0001,
    parameter int                USER_W       = 32,
    parameter logic [IR_W-1:0]   INSTR_IDCODE = IR_W'(4'h1),
    parameter logic [IR_W-1:0]   INSTR_USER   = IR_W'(4'h8)
`ifdef JTAG_USERCODE_EN
    ,
    parameter logic [31:0]       USERCODE_VAL = 32'h0000_0000
`endif
) (
    input  logic              tck,
    input  logic              resetn,
    input  logic              tap_reset,
    input  logic              capture_ir,
    input  logic              shift_ir,
    input  logic              update_ir,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              update_dr,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_en,
    output logic [IR_W-1:0]   ir_out,
    input  logic [USER_W-1:0] user_dr_in,
    output logic [USER_W-1:0] user_dr_out,
    output logic              user_dr_upd
);
    logic [IR_W-1:0]   ir_sr;
    logic              bypass_sr;
    logic [31:0]       idcode_sr;
    logic [USER_W-1:0] user_sr;
    logic              sel_idcode, sel_user, sel_usercode, sel_bypass;
    logic              usercode_bit, dr_bit, tdo_d, user_upd;

    assign sel_idcode = ir_out == INSTR_IDCODE;
    assign sel_user   = !sel_idcode && ir_out == INSTR_USER;
    assign sel_bypass = !(sel_idcode || sel_user || sel_usercode);
    assign user_upd   = !tap_reset && update_dr && sel_user;

`ifdef JTAG_USERCODE_EN
    logic [31:0] usercode_sr;
    assign sel_usercode = !sel_idcode && !sel_user && ir_out == IR_W'(2);
    assign usercode_bit = usercode_sr[0];
    always_ff @(posedge tck or negedge resetn)
        if (!resetn)
            usercode_sr <= '0;
        else if (sel_usercode && capture_dr)
            usercode_sr <= USERCODE_VAL;
        else if (sel_usercode && shift_dr)
            usercode_sr <= {tdi, usercode_sr[31:1]};
`else
    assign sel_usercode = 1'b0;
    assign usercode_bit = 1'b0;
`endif

    always_comb begin
        dr_bit = sel_idcode ? idcode_sr[0] : sel_user ? user_sr[0] : sel_usercode ? usercode_bit : bypass_sr;
        tdo_d  = shift_ir ? ir_sr[0] : dr_bit;
    end

    // tap_reset outranks update_ir so a TLR always lands on IDCODE
    always_ff @(posedge tck or negedge resetn)
        if (!resetn) begin
            ir_sr  <= '0;
            ir_out <= INSTR_IDCODE;
        end else begin
            if (capture_ir)
                ir_sr <= IR_W'(1);
            else if (shift_ir)
                ir_sr <= {tdi, ir_sr[IR_W-1:1]};
            if (tap_reset)
                ir_out <= INSTR_IDCODE;
            else if (update_ir)
                ir_out <= ir_sr;
        end

    always_ff @(posedge tck or negedge resetn)
        if (!resetn) begin
            bypass_sr <= 1'b0;
            idcode_sr <= '0;
            user_sr   <= '0;
        end else begin
            if (sel_bypass && capture_dr)
                bypass_sr <= 1'b0;
            else if (sel_bypass && shift_dr)
                bypass_sr <= tdi;
            if (sel_idcode && capture_dr)
                idcode_sr <= IDCODE_VAL;
            else if (sel_idcode && shift_dr)
                idcode_sr <= {tdi, idcode_sr[31:1]};
            if (sel_user && capture_dr)
                user_sr <= user_dr_in;
            else if (sel_user && shift_dr)
                user_sr <= {tdi, user_sr[USER_W-1:1]};
        end

    always_ff @(posedge tck or negedge resetn)
        if (!resetn) begin
            user_dr_out <= '0;
            user_dr_upd <= 1'b0;
        end else begin
            user_dr_upd <= user_upd;
            if (user_upd)
                user_dr_out <= user_sr;
        end

    always_ff @(negedge tck or negedge resetn)
        if (!resetn) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= shift_ir || shift_dr;
            if (shift_ir || shift_dr)
                tdo <= tdo_d;
        end
endmodule

// File: tb/tb_jtag_tap_regs.sv
// tb_jtag_tap_regs: scoreboard bench driving TAP strobes and checking TDO bits, IR and USER window.
module tb_jtag_tap_regs;
    localparam logic [31:0] IDC = 32'h1000_0001;
    localparam logic [5:0] CI = 6'b100000, SI = 6'b010000, UI = 6'b001000;
    localparam logic [5:0] CD = 6'b000100, SD = 6'b000010, UD = 6'b000001, NO = 6'b000000;

    logic        tck = 1'b0;
    logic        resetn, tap_reset, capture_ir, shift_ir, update_ir;
    logic        capture_dr, shift_dr, update_dr, tdi, tdo, tdo_en, user_dr_upd;
    logic [3:0]  ir_out;
    logic [31:0] user_dr_in, user_dr_out;
    logic        exp_q[$];
    logic [3:0]  cur_ir;
    int          n_chk = 0, n_pass = 0;

    jtag_tap_regs dut (
        .tck(tck), .resetn(resetn), .tap_reset(tap_reset),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en), .ir_out(ir_out),
        .user_dr_in(user_dr_in), .user_dr_out(user_dr_out), .user_dr_upd(user_dr_upd)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // one tck: drive strobes, check TDO after the falling edge, return just past the rising edge
    task automatic cyc(input logic [5:0] s, input logic t);
        {capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr} = s;
        tdi = t;
        @(negedge tck);
        #1;
        check("tdo_en", 32'(tdo_en), 32'(s[4] | s[1]));
        if (s[4] | s[1])
            check("tdo", 32'(tdo), exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 'x);
        @(posedge tck);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] v);
        cyc(CI, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(i == 0);
            cyc(SI, v[i]);
        end
        check("ir_hold", 32'(ir_out), 32'(cur_ir));
        cyc(UI, 1'b0);
        cur_ir = v;
        check("ir_out", 32'(ir_out), 32'(v));
    endtask

    task automatic dr_scan(input logic [63:0] din, input logic [63:0] exp, input int n, input logic upd);
        cyc(CD, 1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp[i]);
            cyc(SD, din[i]);
        end
        if (upd)
            cyc(UD, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        tap_reset = 1'b0;
        {capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr} = NO;
        tdi = 1'b0;
        user_dr_in = '0;
        cur_ir = 4'h1;
        repeat (2) @(posedge tck);
        #1;
        check("rst_ir", 32'(ir_out), 32'h1);
        check("rst_tdo", 32'(tdo), 32'h0);
        check("rst_tdo_en", 32'(tdo_en), 32'h0);
        check("rst_udo", user_dr_out, 32'h0);
        check("rst_upd", 32'(user_dr_upd), 32'h0);
        resetn = 1'b1;
        cyc(NO, 1'b0);

        dr_scan(64'h0, {32'h0, IDC}, 32, 1'b0);
        cyc(NO, 1'b0);

        load_ir(4'hF);
        dr_scan(64'b1101, 64'b1010, 4, 1'b0);
        cyc(NO, 1'b0);
        check("tdo_hold", 32'(tdo), 32'h1);

        load_ir(4'h8);
        user_dr_in = 32'hDEAD_BEEF;
        dr_scan({32'h0, 32'h1234_5678}, {32'h0, 32'hDEAD_BEEF}, 32, 1'b1);
        check("upd_pulse", 32'(user_dr_upd), 32'h1);
        check("udo", user_dr_out, 32'h1234_5678);
        cyc(NO, 1'b0);
        check("upd_end", 32'(user_dr_upd), 32'h0);

        tap_reset = 1'b1;
        cyc(UI, 1'b0);
        tap_reset = 1'b0;
        cur_ir = 4'h1;
        check("tr_ir", 32'(ir_out), 32'h1);
        check("tr_udo", user_dr_out, 32'h1234_5678);

        dr_scan({32'h0, 32'h5555_5555}, {28'h0, 4'h5, IDC}, 36, 1'b1);
        check("idc_no_upd", 32'(user_dr_upd), 32'h0);

        load_ir(4'h2);
`ifdef JTAG_USERCODE_EN
        dr_scan(64'h0, 64'h0, 32, 1'b0);
`else
        dr_scan(64'b0110, 64'b1100, 4, 1'b0);
`endif

        load_ir(4'h8);
        user_dr_in = 32'hCAFE_F00D;
        dr_scan({32'h0, 32'hFFFF_FFFF}, {32'h0, 32'hCAFE_F00D}, 10, 1'b0);
        shift_dr = 1'b1;
        tdi = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("ar_ir", 32'(ir_out), 32'h1);
        check("ar_tdo", 32'(tdo), 32'h0);
        check("ar_tdo_en", 32'(tdo_en), 32'h0);
        check("ar_udo", user_dr_out, 32'h0);
        check("ar_upd", 32'(user_dr_upd), 32'h0);
        shift_dr = 1'b0;
        @(negedge tck);
        #1;
        resetn = 1'b1;
        @(posedge tck);
        #1;
        cyc(UD, 1'b0);
        cyc(NO, 1'b0);
        check("ar_no_upd", 32'(user_dr_upd), 32'h0);
        check("ar_udo2", user_dr_out, 32'h0);
        check("q_left", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jtag_tap_regs.md
Name: jtag_tap_regs

Overview:
Instruction and data register stage directly downstream of the JTAG TAP state machine. It consumes the TAP's one-hot Capture/Shift/Update and Reset strobes. It implements the IR, the BYPASS, IDCODE and USER data registers, and the registered TDO/TDO-enable output. The USER register is the parallel window into the core-side debug/config logic.

Parameters:
IR_W, 4, instruction register width (>=2)
IDCODE_VAL, 32'h1000_0001, value captured by IDCODE; bit0 must be 1
USER_W, 32, width of USER data register (>=2)
INSTR_IDCODE, 4'h1, IDCODE opcode
INSTR_USER, 4'h8, USER opcode
USERCODE_VAL, 32'h0000_0000, USERCODE value (optional feature only)

Ports:
tck  in  1  test clock; all state on rising edge except TDO stage
resetn  in  1  reset, asynchronous, active-low
tap_reset  in  1  TAP in Test-Logic-Reset (synchronous reset)
capture_ir  in  1  TAP Capture-IR state
shift_ir  in  1  TAP Shift-IR state
update_ir  in  1  TAP Update-IR state
capture_dr  in  1  TAP Capture-DR state
shift_dr  in  1  TAP Shift-DR state
update_dr  in  1  TAP Update-DR state
tdi  in  1  serial data in
tdo  out  1  serial data out, falling-edge registered
tdo_en  out  1  TDO drive enable
ir_out  out  IR_W  active instruction
user_dr_in  in  USER_W  parallel capture value for USER
user_dr_out  out  USER_W  parallel update value from USER
user_dr_upd  out  1  one-tck pulse when user_dr_out is written

Behaviour:
- resetn low (async): ir_sr=0, ir_out=INSTR_IDCODE, bypass=0, all DR shift regs=0, user_dr_out=0, user_dr_upd=0, tdo=0, tdo_en=0.
- tap_reset high at a rising edge:
  - ir_out<=INSTR_IDCODE and user_dr_upd<=0.
  - Takes priority over update_ir.
  - user_dr_out is retained.
- IR path:
  - capture_ir: ir_sr<={0..0,2'b01}.
  - shift_ir: ir_sr<={tdi,ir_sr[IR_W-1:1]}, LSB out first.
  - update_ir: ir_out<=ir_sr.
  - If capture and shift are both high (illegal), capture wins.
- DR select, decoded from ir_out:
  - INSTR_IDCODE -> IDCODE reg.
  - INSTR_USER -> USER reg.
  - All ones or any undefined code -> BYPASS.
- BYPASS: capture_dr loads 0; shift_dr loads tdi. One bit, so TDI->TDO delay is 1 tck.
- IDCODE: capture_dr loads IDCODE_VAL; shift_dr shifts right with tdi into the MSB; update_dr has no effect.
- USER:
  - capture_dr loads user_dr_in; shift_dr shifts right with tdi into the MSB.
  - update_dr: user_dr_out<=shift reg; user_dr_upd=1 for exactly one tck cycle.
- Unselected DR shift registers hold their value during DR states.
- TDO mux: shift_ir -> ir_sr[0]; shift_dr -> selected DR bit0; otherwise don't-care.
- TDO timing:
  - tdo and tdo_en (=shift_ir|shift_dr) are registered on the falling tck edge.
  - tdo holds its last value when tdo_en=0.
  - Latency: the bit presented at a rising edge appears on tdo at the following falling edge.
- Shift length is unbounded: a shift longer than the register width wraps tdi bits through.
- ir_out changes only on update_ir or a reset, never mid-shift.
- resetn asserted mid-shift aborts the shift immediately; no update is generated.

Optional Feature:
- Macro: JTAG_USERCODE_EN.
- Defined: opcode 4'h2 selects a 32-bit USERCODE register. Capture loads USERCODE_VAL; shift and TDO behave as for IDCODE.
- Not defined: 4'h2 is an undefined code and decodes to BYPASS.

Test Plan:
- Release resetn, no shifts; ir_out==4'h1. Capture-DR, 32 Shift-DR -> tdo LSB-first serial of 32'h1000_0001; tdo_en high only while shifting.
- Shift IR=4'hF and update; capture-DR, shift tdi pattern 1,0,1,1 -> tdo 0,1,0,1 (one-bit delay, first bit is captured 0).
- Capture-IR, 4 shifts with tdi=0 -> tdo bits 1,0,0,0; ir_out unchanged until Update-IR.
- IR=4'h8, user_dr_in=32'hDEAD_BEEF, capture and 32 shifts of tdi=32'h1234_5678 -> tdo=32'hDEAD_BEEF. Update -> user_dr_out=32'h1234_5678, user_dr_upd one-cycle pulse.
- IR=4'h8, tap_reset pulse -> ir_out=4'h1, user_dr_out unchanged. resetn low mid-USER-shift -> all outputs at reset values, no user_dr_upd.
- IR=4'h2: with JTAG_USERCODE_EN, capture/shift returns USERCODE_VAL. Without it, the path behaves as BYPASS (1-bit delay).
